// File: rtl/nettlp_cmd_responder.sv
// nettlp_cmd_responder: pops NetTLP commands, executes them on the adapter register bank, returns one reply each.
module nettlp_cmd_responder #(
    parameter logic [31:0] MAGIC_VALUE = 32'h4E54_4C50,
    parameter logic [47:0] DEF_DSTMAC  = 48'h0,
    parameter logic [47:0] DEF_SRCMAC  = 48'h0,
    parameter logic [31:0] DEF_DSTIP   = 32'h0,
    parameter logic [31:0] DEF_SRCIP   = 32'h0,
    parameter logic [15:0] DEF_DSTPORT = 16'h3000,
    parameter logic [15:0] DEF_SRCPORT = 16'h3000
) (
    input  logic        clk156,
    input  logic        rst156_n,
    input  logic        cmd_fifo_empty,
    output logic        cmd_fifo_rd_en,
    input  logic [63:0] cmd_fifo_dout,
    output logic        rep_valid,
    input  logic        rep_ready,
    output logic [47:0] rep_data,
    output logic [15:0] rep_udp_check,
    output logic [47:0] cfg_dstmac,
    output logic [47:0] cfg_srcmac,
    output logic [31:0] cfg_dstip,
    output logic [31:0] cfg_srcip,
    output logic [15:0] cfg_dstport,
    output logic [15:0] cfg_srcport,
    output logic [15:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, LATCH, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [63:0] cmd;
    logic [31:0] tstamp;
    logic [7:0]  op, addr, rep_op;
    logic [31:0] wdata, rd_val, wr_val, rep_dat;
    logic        addr_ok, err;

    assign op        = cmd[47:40];
    assign addr      = cmd[39:32];
    assign wdata     = cmd[31:0];
    assign addr_ok   = addr <= 8'h08;
    assign rep_valid = state == RESP;
    // Read-back value after a write: MAGIC is immutable, 16-bit fields drop data[31:16].
    assign wr_val = addr == 8'h00 ? MAGIC_VALUE :
                    (addr == 8'h02 || addr == 8'h04 || addr == 8'h07 || addr == 8'h08) ?
                    {16'h0, wdata[15:0]} : wdata;

    always_comb begin
        rd_val = 32'h0;
        case (addr)
            8'h00: rd_val = MAGIC_VALUE;
            8'h01: rd_val = cfg_dstmac[31:0];
            8'h02: rd_val = {16'h0, cfg_dstmac[47:32]};
            8'h03: rd_val = cfg_srcmac[31:0];
            8'h04: rd_val = {16'h0, cfg_srcmac[47:32]};
            8'h05: rd_val = cfg_dstip;
            8'h06: rd_val = cfg_srcip;
            8'h07: rd_val = {16'h0, cfg_dstport};
            8'h08: rd_val = {16'h0, cfg_srcport};
            default: rd_val = 32'h0;
        endcase
    end

    always_comb begin
        rep_dat = 32'h0;
        err     = 1'b0;
        case (op)
            8'h10: begin rep_dat = addr_ok ? rd_val : 32'h0; err = !addr_ok; end
            8'h11: begin rep_dat = addr_ok ? wr_val : 32'h0; err = !addr_ok; end
            8'h20: rep_dat = MAGIC_VALUE;
            8'h21: rep_dat = tstamp;
            8'h22: rep_dat = 32'h0;
            default: err = 1'b1;
        endcase
        rep_op = err ? 8'hFF : op;
    end

    always_comb begin
        state_nxt      = state;
        cmd_fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                cmd_fifo_rd_en = !cmd_fifo_empty;
                state_nxt      = cmd_fifo_empty ? IDLE : LATCH;
            end
            LATCH: state_nxt = EXEC;
            EXEC:  state_nxt = RESP;
            RESP:  state_nxt = rep_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge rst156_n) begin
        if (!rst156_n) begin
            state         <= IDLE;
            cmd           <= 64'h0;
            tstamp        <= 32'h0;
            rep_data      <= 48'h0;
            rep_udp_check <= 16'h0;
            err_cnt       <= 16'h0;
            cfg_dstmac    <= DEF_DSTMAC;
            cfg_srcmac    <= DEF_SRCMAC;
            cfg_dstip     <= DEF_DSTIP;
            cfg_srcip     <= DEF_SRCIP;
            cfg_dstport   <= DEF_DSTPORT;
            cfg_srcport   <= DEF_SRCPORT;
        end else begin
            state  <= state_nxt;
            tstamp <= tstamp + 32'd1;
            if (state == LATCH) cmd <= cmd_fifo_dout;
            if (state == EXEC) begin
                rep_data      <= {rep_op, addr, rep_dat};
                rep_udp_check <= cmd[63:48];
                if (err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (op == 8'h11) begin
                    case (addr)
                        8'h01: cfg_dstmac[31:0]  <= wdata;
                        8'h02: cfg_dstmac[47:32] <= wdata[15:0];
                        8'h03: cfg_srcmac[31:0]  <= wdata;
                        8'h04: cfg_srcmac[47:32] <= wdata[15:0];
                        8'h05: cfg_dstip         <= wdata;
                        8'h06: cfg_srcip         <= wdata;
                        8'h07: cfg_dstport       <= wdata[15:0];
                        8'h08: cfg_srcport       <= wdata[15:0];
                        default: ;
                    endcase
                end
                if (op == 8'h22) begin
                    cfg_dstmac  <= DEF_DSTMAC;
                    cfg_srcmac  <= DEF_SRCMAC;
                    cfg_dstip   <= DEF_DSTIP;
                    cfg_srcip   <= DEF_SRCIP;
                    cfg_dstport <= DEF_DSTPORT;
                    cfg_srcport <= DEF_SRCPORT;
                end
            end
        end
    end
endmodule

// File: tb/tb_nettlp_cmd_responder.sv
// tb_nettlp_cmd_responder: directed checks of command execution, reply timing and reset behaviour.
module tb_nettlp_cmd_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en, rep_valid;
    logic        rep_ready = 1'b1;
    logic [63:0] dout = 64'h0;
    logic [47:0] rep_data, cfg_dstmac, cfg_srcmac;
    logic [15:0] rep_udp, cfg_dstport, cfg_srcport, err_cnt;
    logic [31:0] cfg_dstip, cfg_srcip;
    logic [63:0] mem [32];
    int          wp = 0, rp = 0;
    int          n_cmp = 0, n_bad = 0;
    logic        empty;

    always #5 clk = ~clk;
    assign empty = wp == rp;

    always @(posedge clk) if (rd_en) begin
        dout <= mem[rp];
        rp   <= rp + 1;
    end

    nettlp_cmd_responder dut (
        .clk156(clk), .rst156_n(rst_n), .cmd_fifo_empty(empty), .cmd_fifo_rd_en(rd_en),
        .cmd_fifo_dout(dout), .rep_valid(rep_valid), .rep_ready(rep_ready),
        .rep_data(rep_data), .rep_udp_check(rep_udp), .cfg_dstmac(cfg_dstmac),
        .cfg_srcmac(cfg_srcmac), .cfg_dstip(cfg_dstip), .cfg_srcip(cfg_srcip),
        .cfg_dstport(cfg_dstport), .cfg_srcport(cfg_srcport), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] c);
        mem[wp % 32] = c;
        wp = wp + 1;
    endtask

    task automatic get_reply(output logic [47:0] d, output logic [15:0] u);
        for (int i = 0; i < 40 && !rep_valid; i++) @(negedge clk);
        check("reply_timeout", {63'h0, rep_valid}, 64'h1);
        d = rep_data;
        u = rep_udp;
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [63:0] c, output logic [47:0] d, output logic [15:0] u);
        push(c);
        get_reply(d, u);
    endtask

    logic [47:0] d, d0;
    logic [15:0] u;
    logic [31:0] t0;
    int          pulses, changed;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_en", {63'h0, rd_en}, 64'h0);
        check("rst_valid", {63'h0, rep_valid}, 64'h0);
        check("rst_data", {16'h0, rep_data}, 64'h0);
        check("rst_err", {48'h0, err_cnt}, 64'h0);
        check("rst_dstport", {48'h0, cfg_dstport}, 64'h3000);
        check("rst_srcport", {48'h0, cfg_srcport}, 64'h3000);
        check("rst_dstip", {32'h0, cfg_dstip}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MAGIC with exact latency
        push({16'hA5A5, 8'h20, 8'h00, 32'h0});
        #1;
        check("lat_rd_en_c0", {63'h0, rd_en}, 64'h1);
        @(negedge clk);
        check("lat_rd_en_c1", {63'h0, rd_en}, 64'h0);
        check("lat_valid_c1", {63'h0, rep_valid}, 64'h0);
        @(negedge clk);
        check("lat_valid_c2", {63'h0, rep_valid}, 64'h0);
        @(negedge clk);
        check("lat_valid_c3", {63'h0, rep_valid}, 64'h1);
        check("magic_data", {16'h0, rep_data}, 64'h20_00_4E544C50);
        check("magic_udp", {48'h0, rep_udp}, 64'hA5A5);
        @(negedge clk);
        check("magic_done", {63'h0, rep_valid}, 64'h0);

        do_cmd({16'h0001, 8'h11, 8'h05, 32'hC0A8_0A01}, d, u);
        check("wr_ip_reply", {16'h0, d}, 64'h11_05_C0A80A01);
        check("wr_ip_cfg", {32'h0, cfg_dstip}, 64'hC0A80A01);
        do_cmd({16'h0002, 8'h10, 8'h05, 32'h0}, d, u);
        check("rd_ip_reply", {16'h0, d}, 64'h10_05_C0A80A01);
        check("rd_ip_udp", {48'h0, u}, 64'h0002);

        do_cmd({16'h0003, 8'h11, 8'h02, 32'hFFFF_1234}, d, u);
        check("wr_mac_hi_reply", {16'h0, d}, 64'h11_02_00001234);
        check("wr_mac_hi_cfg", {16'h0, cfg_dstmac}, 64'h1234_00000000);

        do_cmd({16'h0004, 8'h33, 8'h00, 32'h1}, d, u);
        check("bad_op_reply", {16'h0, d}, 64'hFF_00_00000000);
        do_cmd({16'h0005, 8'h10, 8'h10, 32'h0}, d, u);
        check("bad_addr_reply", {16'h0, d}, 64'hFF_10_00000000);
        check("err_cnt_2", {48'h0, err_cnt}, 64'h2);

        do_cmd({16'h0006, 8'h11, 8'h07, 32'hABCD_1111}, d, u);
        check("wr_port_cfg", {48'h0, cfg_dstport}, 64'h1111);
        do_cmd({16'h0007, 8'h22, 8'h00, 32'h5}, d, u);
        check("rst_all_reply", {16'h0, d}, 64'h22_00_00000000);
        check("rst_all_port", {48'h0, cfg_dstport}, 64'h3000);
        check("rst_all_ip", {32'h0, cfg_dstip}, 64'h0);
        check("rst_all_mac", {16'h0, cfg_dstmac}, 64'h0);
        check("rst_all_err", {48'h0, err_cnt}, 64'h2);

        // backpressure: reply must hold and no second pop
        rep_ready = 1'b0;
        push({16'h1111, 8'h20, 8'h00, 32'h0});
        push({16'h2222, 8'h10, 8'h07, 32'h0});
        pulses = 0;
        changed = 0;
        #1;
        if (rd_en) pulses++;
        repeat (3) begin
            @(negedge clk);
            if (rd_en) pulses++;
        end
        d0 = rep_data;
        repeat (10) begin
            @(negedge clk);
            if (rd_en) pulses++;
            if (rep_data !== d0 || !rep_valid) changed++;
        end
        check("bp_pulses", pulses, 1);
        check("bp_stable", changed, 0);
        check("bp_first_data", {16'h0, d0}, 64'h20_00_4E544C50);
        rep_ready = 1'b1;
        get_reply(d, u);
        check("bp_first_udp", {48'h0, u}, 64'h1111);
        get_reply(d, u);
        check("bp_second_data", {16'h0, d}, 64'h10_07_00003000);
        check("bp_second_udp", {48'h0, u}, 64'h2222);

        push({16'h0008, 8'h21, 8'h00, 32'h0});
        push({16'h0009, 8'h21, 8'h00, 32'h0});
        get_reply(d, u);
        t0 = d[31:0];
        get_reply(d, u);
        check("tstamp_delta", {32'h0, d[31:0] - t0}, 64'h4);

        // reset during EXEC of a write
        push({16'h000A, 8'h11, 8'h05, 32'hDEAD_BEEF});
        #1;
        check("mid_rd_en", {63'h0, rd_en}, 64'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_valid_in_rst", {63'h0, rep_valid}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        changed = 0;
        repeat (8) begin
            @(negedge clk);
            if (rep_valid) changed++;
        end
        check("mid_no_reply", changed, 0);
        check("mid_dstip", {32'h0, cfg_dstip}, 64'h0);
        check("mid_dstport", {48'h0, cfg_dstport}, 64'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
